// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: FSM encoding, the reset/NOP instruction
// word and the word-alignment helper used for branch targets.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1,
      ST_UPDATE = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with its next-PC mux: sequential PC+4 or a word-aligned target.
// The register only moves when load is asserted (the UPDATE cycle).
module pc_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        sel,
   input  logic [31:0] target,
   output logic [31:0] pc,
   output logic [31:0] pc4
);

   logic [31:0] value_reg;
   logic [31:0] value_next;

   // Wraps naturally at 2^32; no carry flag is wanted.
   assign pc4        = value_reg + INSTR_BYTES;
   assign value_next = sel ? align_word(target) : pc4;
   assign pc         = value_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_reg <= RESET_PC;
      end else if (load) begin
         value_reg <= value_next;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: FETCH handshakes with memory, EXEC holds the
// word for EXEC_CYCLES clocks, UPDATE advances the PC.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          EXEC_CYCLES = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PCSel,
   input  logic [31:0] ALUout,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] PC,
   output logic [31:0] PC4,
   output logic        instr_valid,
   output logic [2:0]  cycle
);

   localparam logic [2:0] LAST_CYCLE = 3'(EXEC_CYCLES - 1);

   fetch_state_t state_reg, state_next;
   logic [2:0]   cycle_reg, cycle_next;
   logic [31:0]  instr_reg, instr_next;
   logic [31:0]  target_reg, target_next;
   logic         sel_reg, sel_next;
   logic         armed_reg;
   logic         pc_load;
   logic         fetch_fire;

   // armed_reg keeps the request low during reset and until the first edge after release.
   assign imem_req    = armed_reg && (state_reg == ST_FETCH);
   assign fetch_fire  = imem_req && imem_ack;
   assign imem_addr   = PC;
   assign instr       = instr_reg;
   assign instr_valid = (state_reg == ST_EXEC);
   assign cycle       = cycle_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_FETCH;
         cycle_reg  <= 3'd0;
         instr_reg  <= NOP_INSTR;
         target_reg <= 32'h0000_0000;
         sel_reg    <= 1'b0;
         armed_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cycle_reg  <= cycle_next;
         instr_reg  <= instr_next;
         target_reg <= target_next;
         sel_reg    <= sel_next;
         armed_reg  <= 1'b1;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cycle_next  = cycle_reg;
      instr_next  = instr_reg;
      target_next = target_reg;
      sel_next    = sel_reg;
      pc_load     = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            if (fetch_fire) begin
               instr_next = imem_rdata;
               cycle_next = 3'd0;
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // The branch decision is only trusted on the final execution cycle.
            if (cycle_reg == LAST_CYCLE) begin
               sel_next    = PCSel;
               target_next = ALUout;
               cycle_next  = 3'd0;
               state_next  = ST_UPDATE;
            end else begin
               cycle_next = cycle_reg + 3'd1;
            end
         end
         ST_UPDATE: begin
            pc_load    = 1'b1;
            state_next = ST_FETCH;
         end
         default: begin
            state_next = ST_FETCH;
            cycle_next = 3'd0;
         end
      endcase
   end

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (pc_load),
      .sel    (sel_reg),
      .target (target_reg),
      .pc     (PC),
      .pc4    (PC4)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: directed corner cases plus a randomized run,
// all checked against a simple PC/instruction model kept in the bench.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          EC     = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PCSel = 1'b0;
   logic [31:0] ALUout = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr;
   logic [31:0] PC;
   logic [31:0] PC4;
   logic        instr_valid;
   logic [2:0]  cycle;

   int          total = 0;
   int          passed = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC    (RST_PC),
      .EXEC_CYCLES (EC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PCSel       (PCSel),
      .ALUout      (ALUout),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .PC          (PC),
      .PC4         (PC4),
      .instr_valid (instr_valid),
      .cycle       (cycle)
   );

   // One full instruction: wait for req, ack after 'delay' cycles, walk EXEC, UPDATE.
   task automatic run_instr(input int delay, input logic [31:0] word, input logic sel,
                            input logic [31:0] tgt, input logic spur, input logic decoy);
      int waited;
      logic [31:0] start_pc;
      waited = 0;
      while (imem_req !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      start_pc = exp_pc;
      total++; if (imem_req !== 1'b1) $display("FAIL req_timeout: imem_req=%b want 1", imem_req); else passed++;
      total++; if (imem_addr !== exp_pc) $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_pc); else passed++;
      total++; if (PC4 !== exp_pc + 32'd4) $display("FAIL pc4: got %h want %h", PC4, exp_pc + 32'd4); else passed++;
      for (int d = 0; d < delay; d++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         @(negedge clk);
         total++; if (imem_req !== 1'b1 || imem_addr !== exp_pc)
            $display("FAIL wait_stable: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc);
         else passed++;
         total++; if (instr !== exp_instr || instr_valid !== 1'b0)
            $display("FAIL wait_instr: instr=%h valid=%b want %h valid=0", instr, instr_valid, exp_instr);
         else passed++;
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      exp_instr  = word;
      for (int c = 0; c < EC; c++) begin
         total++; if (cycle !== 3'(c) || instr_valid !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL exec_seq: cycle=%0d valid=%b req=%b want cycle=%0d valid=1 req=0", cycle, instr_valid, imem_req, c);
         else passed++;
         total++; if (instr !== exp_instr || PC !== exp_pc)
            $display("FAIL exec_hold: instr=%h pc=%h want %h pc=%h", instr, PC, exp_instr, exp_pc);
         else passed++;
         if (c == EC - 1) begin
            PCSel  = sel;
            ALUout = tgt;
         end else begin
            PCSel  = decoy ? ~sel : 1'($urandom);
            ALUout = $urandom;
         end
         if (spur && c == 1) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
         end else begin
            imem_ack   = 1'b0;
         end
         @(negedge clk);
      end
      imem_ack = 1'b0;
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || cycle !== 3'd0 || instr !== exp_instr)
         $display("FAIL update: valid=%b req=%b cycle=%0d instr=%h want 0 0 0 %h", instr_valid, imem_req, cycle, instr, exp_instr);
      else passed++;
      PCSel  = 1'($urandom);
      ALUout = $urandom;
      @(negedge clk);
      exp_pc = sel ? (tgt & ~32'h3) : exp_pc + 32'd4;
      total++; if (imem_req !== 1'b1 || imem_addr !== exp_pc)
         $display("FAIL next_fetch: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc);
      else passed++;
      $display("instr pc=%h word=%h delay=%0d sel=%b tgt=%h next=%h", start_pc, word, delay, sel, tgt, exp_pc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
      total++; if (instr_valid !== 1'b0 || cycle !== 3'd0)
         $display("FAIL rst_valid_cycle: valid=%b cycle=%0d want 0 0", instr_valid, cycle);
      else passed++;
      total++; if (PC !== RST_PC || instr !== 32'h0)
         $display("FAIL rst_pc_instr: pc=%h instr=%h want %h 0", PC, instr, RST_PC);
      else passed++;
      rst_n = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0) $display("FAIL rst_release_req: got %b want 0", imem_req); else passed++;
      @(negedge clk);
      total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC)
         $display("FAIL first_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC);
      else passed++;
      exp_pc    = RST_PC;
      exp_instr = 32'h0;
   endtask

   task automatic test_zero_wait();
      run_instr(0, 32'h0000_0033, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_ack_delay();
      run_instr(3, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_branch();
      run_instr(0, $urandom, 1'b1, 32'h0000_0102, 1'b0, 1'b0);
      run_instr(1, $urandom, 1'b0, $urandom, 1'b0, 1'b1);
   endtask

   task automatic test_wrap();
      run_instr(0, $urandom, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_instr(1, $urandom, 1'b0, $urandom, 1'b0, 1'b0);
   endtask

   task automatic test_spurious_ack();
      run_instr(0, $urandom, 1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++)
         run_instr(int'($urandom_range(0, 4)), $urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
   endtask

   task automatic test_reset_mid_exec();
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      imem_ack = 1'b0;
      PCSel    = 1'b1;
      ALUout   = 32'h0000_0800;
      repeat (2) @(negedge clk);
      total++; if (cycle !== 3'd2 || instr_valid !== 1'b1)
         $display("FAIL pre_reset_exec: cycle=%0d valid=%b want 2 1", cycle, instr_valid);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if (instr !== 32'h0 || instr_valid !== 1'b0 || cycle !== 3'd0)
         $display("FAIL async_rst: instr=%h valid=%b cycle=%0d want 0 0 0", instr, instr_valid, cycle);
      else passed++;
      total++; if (PC !== RST_PC || imem_req !== 1'b0)
         $display("FAIL async_rst_pc: pc=%h req=%b want %h 0", PC, imem_req, RST_PC);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC)
         $display("FAIL restart: req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC);
      else passed++;
      exp_pc    = RST_PC;
      exp_instr = 32'h0;
      $display("instr reset during exec, restart at %h", RST_PC);
   endtask

   task automatic test_reset_mid_fetch();
      logic [31:0] word;
      int          waited;
      word     = $urandom;
      PCSel    = 1'b0;
      imem_ack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0 || PC !== RST_PC)
         $display("FAIL fetch_rst: req=%b pc=%h want 0 %h", imem_req, PC, RST_PC);
      else passed++;
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (imem_req !== 1'b1 || instr !== 32'h0 || instr_valid !== 1'b0)
         $display("FAIL late_ack_ignored: req=%b instr=%h valid=%b want 1 0 0", imem_req, instr, instr_valid);
      else passed++;
      @(negedge clk);
      imem_ack = 1'b0;
      total++; if (instr_valid !== 1'b1 || instr !== word || cycle !== 3'd0)
         $display("FAIL late_ack_capture: valid=%b instr=%h cycle=%0d want 1 %h 0", instr_valid, instr, cycle, word);
      else passed++;
      waited = 0;
      while (imem_req !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'd4 || waited !== EC + 1)
         $display("FAIL post_rst_next: req=%b addr=%h gap=%0d want 1 %h %0d", imem_req, imem_addr, waited, RST_PC + 32'd4, EC + 1);
      else passed++;
      $display("instr reset during fetch, word=%h captured after release", word);
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_ack_delay();
      test_branch();
      test_wrap();
      test_spurious_ack();
      test_random();
      test_reset_mid_exec();
      test_reset_mid_fetch();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
